// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the register interface and the UART transmitter.
// Show-ahead output: d_in always presents the head byte with zero read latency.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                     clk,
    input  logic                     a_reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     fifo_clr,
    input  logic                     tx_get_data,
    output logic                     tx_start,
    output logic [7:0]               d_in,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     empty_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          empty_irq_reg, empty_irq_next;
    logic          push_ok, pop_ok;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CW'(DEPTH));
    assign almost_full = (count_reg >= CW'(AFULL_LEVEL));
    assign tx_start    = ~empty;
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign empty_irq   = empty_irq_reg;
    assign d_in        = mem[rd_ptr_reg];

    // A pop frees the slot at this edge, so a push into a full FIFO is accepted alongside it.
    assign pop_ok  = tx_get_data & ~empty;
    assign push_ok = wr_en & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !fifo_clr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        empty_irq_next = 1'b0;
        if (fifo_clr) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (wr_en && full && !pop_ok) begin
                overflow_next = 1'b1;
            end
            if (tx_get_data && empty) begin
                underflow_next = 1'b1;
            end
            empty_irq_next = pop_ok & ~push_ok & (count_reg == CW'(1));
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            empty_irq_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            empty_irq_reg <= empty_irq_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a byte queue models the FIFO contents
// and the flags; every cycle the DUT outputs are compared against it.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 14;

    logic       clk = 1'b0;
    logic       a_reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_clr = 1'b0;
    logic       tx_get_data = 1'b0;
    logic       tx_start;
    logic [7:0] d_in;
    logic       full, empty, almost_full;
    logic [4:0] count;
    logic       overflow, underflow, empty_irq;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       m_irq = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk        (clk),
        .a_reset    (a_reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_clr   (fifo_clr),
        .tx_get_data(tx_get_data),
        .tx_start   (tx_start),
        .d_in       (d_in),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .empty_irq  (empty_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags();
        int sz;
        sz = sb_q.size();
        check_eq("count", 32'(count), 32'(sz));
        check_eq("empty", 32'(empty), 32'(sz == 0));
        check_eq("full", 32'(full), 32'(sz == DEPTH));
        check_eq("almost_full", 32'(almost_full), 32'(sz >= AFULL));
        check_eq("tx_start", 32'(tx_start), 32'(sz != 0));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_udf));
        check_eq("empty_irq", 32'(empty_irq), 32'(m_irq));
        if (sz != 0) check_eq("d_in_head", 32'(d_in), 32'(sb_q[0]));
    endtask

    // One clock cycle with the given inputs; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic wr, input logic [7:0] data, input logic rd, input logic clr);
        int  sz;
        logic pop_ok, push_ok;
        wr_en = wr; wr_data = data; tx_get_data = rd; fifo_clr = clr;
        @(negedge clk);
        sz = sb_q.size();
        if (rd && sz != 0) check_eq("d_in_pop", 32'(d_in), 32'(sb_q[0]));
        if (clr) begin
            sb_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
        end else begin
            pop_ok  = rd && sz != 0;
            push_ok = wr && (sz < DEPTH || pop_ok);
            m_irq   = pop_ok && !push_ok && sz == 1;
            if (rd && sz == 0) m_udf = 1'b1;
            if (wr && sz == DEPTH && !rd) m_ovf = 1'b1;
            if (pop_ok) void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(data);
        end
        @(posedge clk);
        #1;
        $display("cyc wr=%0b data=%02h rd=%0b clr=%0b -> count=%0d d_in=%02h ovf=%0b udf=%0b irq=%0b",
                 wr, data, rd, clr, count, d_in, overflow, underflow, empty_irq);
        check_flags();
        wr_en = 1'b0; tx_get_data = 1'b0; fifo_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_flags();
        @(negedge clk);
        a_reset = 1'b0;
        @(posedge clk);
        #1;

        // Single byte round trip with empty interrupt
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("a5_d_in", 32'(d_in), 32'h A5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("a5_irq", 32'(empty_irq), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("a5_irq_gone", 32'(empty_irq), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        check_eq("full_rw_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Interleaved traffic so the pointers wrap
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'hB0 + i), (i % 3) != 0, 1'b0);
        while (sb_q.size() != 0) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow, then clear overriding a push
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("udf_set", 32'(underflow), 32'd1);
        cyc(1'b1, 8'h11, 1'b0, 1'b1);
        check_eq("clr_udf", 32'(underflow), 32'd0);
        cyc(1'b1, 8'h22, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        a_reset = 1'b1;
        #2;
        sb_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0;
        check_eq("async_count", 32'(count), 32'd0);
        check_eq("async_tx_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        a_reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        check_eq("post_reset_d_in", 32'(d_in), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
                1'($urandom_range(0, 40) == 0 ? 1 : 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
